// File: rtl/scan_pkg.sv
// Shared types and constants for the frame-scan controller.
// The optional no-digit watchdog is enabled by defining SCAN_TIMEOUT_EN.
package scan_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int          COORD_W      = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HSCAN = 3'd1,
    VSCAN = 3'd2,
    RECOG = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  function automatic logic is_scan_state(input scan_state_t st);
    return (st == HSCAN) || (st == VSCAN) || (st == RECOG);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column coordinate registers for the frame scan.
// The counter steps in raster order, or in column-major order when transposed.
module raster_counter
  import scan_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic               transpose,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(H_ACTIVE - 1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic               last_row;
  logic               last_col;

  assign last_row = (row_q == ROW_LAST);
  assign last_col = (col_q == COL_LAST);

  // Reports that this cycle's step would roll over to (0,0); independent of
  // clear so the sequencer can use it to decide the transition itself.
  assign wrap = enable & last_row & last_col;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (transpose) begin
        if (last_row) begin
          row_d = '0;
          col_d = last_col ? '0 : col_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/scan_sequencer.sv
// Frame-scan controller: sequences HSCAN -> VSCAN -> RECOG over the frame buffer.
// Define SCAN_TIMEOUT_EN to end a scan phase after two full passes with no edges.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [1:0]           iEdgeDone,
  input  logic                 iRecogFin,
  output logic [COORD_W-1:0]   oRow,
  output logic [COORD_W-1:0]   oCol,
  output logic [ADDR_W-1:0]    oAddr,
  output logic                 oHscan,
  output logic                 oVscan,
  output logic                 oEnEdge,
  output logic                 oEnRecog,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oTimeout
);

  scan_state_t        state_q, state_d;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_transpose;
  logic               cnt_wrap;
  logic               timeout_d;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [ADDR_W-1:0]  row_ext;

  logic hscan_q, vscan_q, en_edge_q, en_recog_q, busy_q, done_q;

`ifdef SCAN_TIMEOUT_EN
  logic wrap_seen_q, wrap_seen_d;
  logic timeout_q;
`else
  logic cnt_wrap_unused;
  assign cnt_wrap_unused = cnt_wrap;
`endif

  // Phase transitions take priority over counting; a watchdog expiry only
  // fires when the phase's own done input is low on the wrapping cycle.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: if (iStart) state_d = HSCAN;
      HSCAN: begin
        if (iEdgeDone[0]) begin
          state_d = VSCAN;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (cnt_wrap && wrap_seen_q) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
`endif
      end
      VSCAN: begin
        if (iEdgeDone[1]) begin
          state_d = RECOG;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (cnt_wrap && wrap_seen_q) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
`endif
      end
      RECOG: if (iRecogFin) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cnt_clear     = (state_d != state_q);
  assign cnt_enable    = is_scan_state(state_q);
  assign cnt_transpose = (state_q == VSCAN);

`ifdef SCAN_TIMEOUT_EN
  always_comb begin
    wrap_seen_d = wrap_seen_q;
    if (cnt_clear) begin
      wrap_seen_d = 1'b0;
    end else if (cnt_wrap) begin
      wrap_seen_d = 1'b1;
    end
  end
`endif

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .transpose (cnt_transpose),
    .row_o     (row),
    .col_o     (col),
    .wrap      (cnt_wrap)
  );

  // Status outputs are decoded from the next state so they line up with the
  // state register and the freshly cleared coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hscan_q    <= 1'b0;
      vscan_q    <= 1'b0;
      en_edge_q  <= 1'b0;
      en_recog_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      wrap_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hscan_q    <= (state_d == HSCAN) || (state_d == RECOG);
      vscan_q    <= (state_d == VSCAN);
      en_edge_q  <= (state_d == HSCAN) || (state_d == VSCAN);
      en_recog_q <= (state_d == RECOG);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
`ifdef SCAN_TIMEOUT_EN
      wrap_seen_q <= wrap_seen_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Row * 640 as shift-and-add; only valid for the default 640-pixel row.
  assign row_ext = ADDR_W'(row);
  assign oAddr   = (row_ext << 9) + (row_ext << 7) + ADDR_W'(col);

  assign oRow     = row;
  assign oCol     = col;
  assign oHscan   = hscan_q;
  assign oVscan   = vscan_q;
  assign oEnEdge  = en_edge_q;
  assign oEnRecog = en_recog_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
`ifdef SCAN_TIMEOUT_EN
  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; a second, tiny-frame instance covers
// the full-pass wrap and the SCAN_TIMEOUT_EN watchdog in few cycles.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iStart = 1'b0;
  logic [1:0]  iEdgeDone = 2'b00;
  logic        iRecogFin = 1'b0;
  logic [9:0]  oRow, oCol;
  logic [18:0] oAddr;
  logic        oHscan, oVscan, oEnEdge, oEnRecog, oBusy, oDone, oTimeout;

  logic        s_start = 1'b0;
  logic [1:0]  s_edge = 2'b00;
  logic        s_fin = 1'b0;
  logic [9:0]  s_row, s_col;
  logic [18:0] s_addr;
  logic        s_hscan, s_vscan, s_en_edge, s_en_recog, s_busy, s_done, s_timeout;

  always #5 clk = ~clk;

  scan_sequencer u_dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iEdgeDone(iEdgeDone), .iRecogFin(iRecogFin),
    .oRow(oRow), .oCol(oCol), .oAddr(oAddr), .oHscan(oHscan), .oVscan(oVscan),
    .oEnEdge(oEnEdge), .oEnRecog(oEnRecog), .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout)
  );

  scan_sequencer #(.H_ACTIVE(8), .V_ACTIVE(4)) u_small (
    .clk(clk), .rst(rst), .iStart(s_start), .iEdgeDone(s_edge), .iRecogFin(s_fin),
    .oRow(s_row), .oCol(s_col), .oAddr(s_addr), .oHscan(s_hscan), .oVscan(s_vscan),
    .oEnEdge(s_en_edge), .oEnRecog(s_en_recog), .oBusy(s_busy), .oDone(s_done), .oTimeout(s_timeout)
  );

  // Flag order: {hscan, vscan, en_edge, en_recog, busy, done, timeout}
  localparam logic [6:0] F_I  = 7'b0000000;
  localparam logic [6:0] F_H  = 7'b1010100;
  localparam logic [6:0] F_V  = 7'b0110100;
  localparam logic [6:0] F_R  = 7'b1001100;
  localparam logic [6:0] F_D  = 7'b0000110;
  localparam logic [6:0] F_DT = 7'b0000111;

  int vecs = 0;
  int errs = 0;
  logic [45:0] obs, expv;

  function automatic logic [45:0] snap();
    return {oRow, oCol, oAddr, oHscan, oVscan, oEnEdge, oEnRecog, oBusy, oDone, oTimeout};
  endfunction

  function automatic logic [45:0] snap_s();
    return {s_row, s_col, s_addr, s_hscan, s_vscan, s_en_edge, s_en_recog, s_busy, s_done, s_timeout};
  endfunction

  function automatic logic [45:0] exp_vec(input int row, input int col, input logic [6:0] f);
    logic [18:0] a;
    a = 19'(row * 640 + col);
    return {10'(row), 10'(col), a, f};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL reset_held: got %h want %h", obs, expv); errs++; end
    vecs++;
    rst = 1'b1;
    tick(10);
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL idle_10: got %h want %h", obs, expv); errs++; end
    vecs++;
    $display("reset: idle after 10 cycles, row=%0d col=%0d busy=%0b", oRow, oCol, oBusy);
  endtask

  task automatic test_hscan();
    iStart = 1'b1;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL hscan_entry: got %h want %h", obs, expv); errs++; end
    vecs++;
    iStart = 1'b0;
    tick(1);
    obs = snap(); expv = exp_vec(0, 1, F_H);
    if (obs !== expv) begin $display("FAIL hscan_step: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(639);
    obs = snap(); expv = exp_vec(1, 0, F_H);
    if (obs !== expv) begin $display("FAIL hscan_row_wrap: got %h want %h", obs, expv); errs++; end
    vecs++;
    $display("hscan: after 640 cycles row=%0d col=%0d addr=%0d", oRow, oCol, oAddr);
  endtask

  task automatic test_vscan();
    tick(2570);
    obs = snap(); expv = exp_vec(5, 10, F_H);
    if (obs !== expv) begin $display("FAIL hscan_5_10: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b01;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_V);
    if (obs !== expv) begin $display("FAIL vscan_entry: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b00;
    tick(1);
    obs = snap(); expv = exp_vec(1, 0, F_V);
    if (obs !== expv) begin $display("FAIL vscan_step: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(479);
    obs = snap(); expv = exp_vec(0, 1, F_V);
    if (obs !== expv) begin $display("FAIL vscan_col_wrap: got %h want %h", obs, expv); errs++; end
    vecs++;
    // Inputs belonging to other states must not disturb VSCAN
    iStart = 1'b1; iRecogFin = 1'b1; iEdgeDone = 2'b01;
    tick(1);
    obs = snap(); expv = exp_vec(1, 1, F_V);
    if (obs !== expv) begin $display("FAIL vscan_ignore: got %h want %h", obs, expv); errs++; end
    vecs++;
    iStart = 1'b0; iRecogFin = 1'b0; iEdgeDone = 2'b00;
    $display("vscan: entered at (0,0), now row=%0d col=%0d addr=%0d", oRow, oCol, oAddr);
  endtask

  task automatic test_recog();
    iEdgeDone = 2'b10;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_R);
    if (obs !== expv) begin $display("FAIL recog_entry: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b11; iStart = 1'b1;
    tick(641);
    obs = snap(); expv = exp_vec(1, 1, F_R);
    if (obs !== expv) begin $display("FAIL recog_raster: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b00; iRecogFin = 1'b1;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_D);
    if (obs !== expv) begin $display("FAIL done_pulse: got %h want %h", obs, expv); errs++; end
    vecs++;
    iRecogFin = 1'b0;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL done_to_idle: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL restart_held_start: got %h want %h", obs, expv); errs++; end
    vecs++;
    iStart = 1'b0;
    $display("recog: done pulse seen, restarted into HSCAN with start held");
  endtask

  task automatic test_back_to_back();
    tick(3);
    obs = snap(); expv = exp_vec(0, 3, F_H);
    if (obs !== expv) begin $display("FAIL b2b_hscan: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b11;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_V);
    if (obs !== expv) begin $display("FAIL b2b_vscan_min: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_R);
    if (obs !== expv) begin $display("FAIL b2b_recog: got %h want %h", obs, expv); errs++; end
    vecs++;
    iEdgeDone = 2'b00;
    tick(2);
    obs = snap(); expv = exp_vec(0, 2, F_R);
    if (obs !== expv) begin $display("FAIL b2b_recog_count: got %h want %h", obs, expv); errs++; end
    vecs++;
    iRecogFin = 1'b1;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_D);
    if (obs !== expv) begin $display("FAIL b2b_done: got %h want %h", obs, expv); errs++; end
    vecs++;
    iRecogFin = 1'b0;
    tick(2);
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL b2b_idle_stays: got %h want %h", obs, expv); errs++; end
    vecs++;
    $display("back_to_back: edges 11 gave one VSCAN cycle then RECOG, done, idle");
  endtask

  task automatic test_async_reset();
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0; iEdgeDone = 2'b01;
    tick(1);
    iEdgeDone = 2'b00;
    tick(1060);
    obs = snap(); expv = exp_vec(100, 2, F_V);
    if (obs !== expv) begin $display("FAIL vscan_100_2: got %h want %h", obs, expv); errs++; end
    vecs++;
    #3 rst = 1'b0;
    #1;
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL async_reset: got %h want %h", obs, expv); errs++; end
    vecs++;
    #2 rst = 1'b1;
    tick(1);
    obs = snap(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL post_reset_idle: got %h want %h", obs, expv); errs++; end
    vecs++;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    obs = snap(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL post_reset_start: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(1);
    obs = snap(); expv = exp_vec(0, 1, F_H);
    if (obs !== expv) begin $display("FAIL post_reset_step: got %h want %h", obs, expv); errs++; end
    vecs++;
    $display("async_reset: outputs cleared before clock edge, restart at HSCAN (0,0)");
  endtask

  task automatic test_watchdog();
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    obs = snap_s(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL small_entry: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(9);
    obs = snap_s(); expv = exp_vec(1, 1, F_H);
    if (obs !== expv) begin $display("FAIL small_addr: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(23);
    obs = snap_s(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL small_first_wrap: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(31);
    obs = snap_s(); expv = exp_vec(3, 7, F_H);
    if (obs !== expv) begin $display("FAIL small_last_pixel: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(1);
`ifdef SCAN_TIMEOUT_EN
    obs = snap_s(); expv = exp_vec(0, 0, F_DT);
    if (obs !== expv) begin $display("FAIL watchdog_done: got %h want %h", obs, expv); errs++; end
    vecs++;
    tick(1);
    obs = snap_s(); expv = exp_vec(0, 0, F_I);
    if (obs !== expv) begin $display("FAIL watchdog_idle: got %h want %h", obs, expv); errs++; end
    vecs++;
`else
    obs = snap_s(); expv = exp_vec(0, 0, F_H);
    if (obs !== expv) begin $display("FAIL no_watchdog_wrap: got %h want %h", obs, expv); errs++; end
    vecs++;
`endif
    $display("watchdog: after two passes row=%0d col=%0d done=%0b timeout=%0b", s_row, s_col, s_done, s_timeout);
  endtask

  initial begin
    test_reset();
    test_hscan();
    test_vscan();
    test_recog();
    test_back_to_back();
    test_async_reset();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
